// File: rtl/key_led_ctrl_pkg.sv
// Shared definitions for the key-to-LED controller:
// per-channel mode encodings and the mode advance rule.
package key_led_ctrl_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2
  } mode_e;

  // Encoding 3 is unreachable and behaves as OFF.
  function automatic logic [MODE_W-1:0] mode_next(
    input logic [MODE_W-1:0] m
  );
    logic [MODE_W-1:0] r;
    r = MODE_ON;
    unique case (1'b1)
      (m == MODE_ON):    r = MODE_BLINK;
      (m == MODE_BLINK): r = MODE_OFF;
      default:           r = MODE_ON;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop sync, debounce, press pulse.
// Ports: sys_clk, sys_rst_n (sync, low), key_in (raw,
// active-low), key_press (1-cycle pulse on accepted press).
module key_debounce #(
  parameter logic [31:0] DEBOUNCE_CNT = 32'd1000000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_press
);

  logic        r_s1;
  logic        r_s2;
  logic        r_deb;
  logic        r_deb_d;
  logic        r_press;
  logic [31:0] r_cnt;
  logic        w_mis;
  logic        w_done;

  assign w_mis  = r_s2 != r_deb;
  assign w_done = w_mis &&
    (r_cnt == DEBOUNCE_CNT - 32'd1);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_deb   <= 1'b1;
      r_deb_d <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= 32'd0;
    end else begin
      r_s1    <= key_in;
      r_s2    <= r_s1;
      r_deb_d <= r_deb;
      // falling edge of the debounced level
      r_press <= r_deb_d & ~r_deb;
      if (!w_mis) begin
        r_cnt <= 32'd0;
      end else if (w_done) begin
        r_cnt <= 32'd0;
        r_deb <= r_s2;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign key_press = r_press;

endmodule

// File: rtl/key_led_ctrl.sv
// N-channel key-to-LED controller: each press cycles
// OFF->ON->BLINK->OFF; all keys pressed together clear all.
// Ports: sys_clk, sys_rst_n (sync, low), key[N] (raw,
// active-low), key_press[N] (press pulses), led[N] (drive).
module key_led_ctrl
  import key_led_ctrl_pkg::*;
#(
  parameter int          KEY_NUM      = 2,
  parameter logic [31:0] DEBOUNCE_CNT = 32'd1000000,
  parameter logic [31:0] BLINK_CNT    = 32'd25000000,
  parameter logic        LED_ACTIVE   = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] led
);

  logic [KEY_NUM-1:0] w_press;
  logic [31:0]        r_div;
  logic               r_phase;
  logic [MODE_W-1:0]  r_mode [KEY_NUM];
  logic [MODE_W-1:0]  w_mode_nxt [KEY_NUM];
  logic [KEY_NUM-1:0] r_led;
  logic [KEY_NUM-1:0] w_led;
  logic               w_all_off;

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
    key_debounce #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_deb (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .key_in   (key[g]),
      .key_press(w_press[g])
    );
  end

  assign key_press = w_press;

  // Free-running shared divider keeps all blinkers in phase.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_div   <= 32'd0;
      r_phase <= 1'b0;
    end else if (r_div == BLINK_CNT - 32'd1) begin
      r_div   <= 32'd0;
      r_phase <= ~r_phase;
    end else begin
      r_div <= r_div + 32'd1;
    end
  end

  // A lone key can never mean "clear everything".
  assign w_all_off = (KEY_NUM >= 2) && (&w_press);

  always_comb begin
    for (int i = 0; i < KEY_NUM; i++) begin
      w_mode_nxt[i] = r_mode[i];
      if (w_all_off) begin
        w_mode_nxt[i] = MODE_OFF;
      end else if (w_press[i]) begin
        w_mode_nxt[i] = mode_next(r_mode[i]);
      end
    end
  end

  always_comb begin
    w_led = {KEY_NUM{~LED_ACTIVE}};
    for (int i = 0; i < KEY_NUM; i++) begin
      unique case (1'b1)
        (r_mode[i] == MODE_ON):
          w_led[i] = LED_ACTIVE;
        (r_mode[i] == MODE_BLINK):
          w_led[i] = r_phase ? LED_ACTIVE : ~LED_ACTIVE;
        default:
          w_led[i] = ~LED_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < KEY_NUM; i++) begin
        r_mode[i] <= MODE_OFF;
      end
      r_led <= {KEY_NUM{~LED_ACTIVE}};
    end else begin
      for (int i = 0; i < KEY_NUM; i++) begin
        r_mode[i] <= w_mode_nxt[i];
      end
      r_led <= w_led;
    end
  end

  assign led = r_led;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Bench for key_led_ctrl: directed scenarios plus random
// key patterns, checked cycle by cycle against a model.
module tb_key_led_ctrl;

  localparam int N = 2;
  localparam int D = 4;
  localparam int B = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] key = '1;
  logic [N-1:0] key_press;
  logic [N-1:0] led;

  always #5 clk = ~clk;

  key_led_ctrl #(
    .KEY_NUM     (N),
    .DEBOUNCE_CNT(32'd4),
    .BLINK_CNT   (32'd5),
    .LED_ACTIVE  (1'b1)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .key      (key),
    .key_press(key_press),
    .led      (led)
  );

  typedef struct packed {
    logic [N-1:0] press;
    logic [N-1:0] led;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   done = 0;

  bit   k1 [N];
  bit   k2 [N];
  bit   lv [N];
  bit   lp [N];
  bit   pa [N];
  int   run [N];
  int   mode [N];
  int   n;
  exp_t e;
  bit   pnew [N];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        k1[i] = 1; k2[i] = 1; lv[i] = 1; lp[i] = 1;
        pa[i] = 0; run[i] = 0; mode[i] = 0;
      end
      n = 0;
      e = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        e.led[i] = (mode[i] == 1) ||
                   (mode[i] == 2 && ((n / B) % 2 == 1));
        pnew[i] = lp[i] & ~lv[i];
      end
      if (pa[0] && pa[1]) begin
        for (int i = 0; i < N; i++) mode[i] = 0;
      end else begin
        for (int i = 0; i < N; i++)
          if (pa[i]) mode[i] = (mode[i] + 1) % 3;
      end
      for (int i = 0; i < N; i++) begin
        lp[i] = lv[i];
        if (k2[i] != lv[i]) begin
          run[i]++;
          if (run[i] == D) begin
            lv[i] = k2[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
        k2[i] = k1[i];
        k1[i] = key[i];
        pa[i] = pnew[i];
        e.press[i] = pnew[i];
      end
      n++;
    end
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      tests++;
      if ({key_press, led} !== {x.press, x.led}) begin
        fails++;
        $display("FAIL outputs t=%0t press=%b led=%b want press=%b led=%b",
                 $time, key_press, led, x.press, x.led);
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    if (!done) begin
      fails++;
      $display("FAIL timeout: sequence did not finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic step(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; key = 2'b11; step(10);
    tests++;
    if (led !== 2'b00 || key_press !== 2'b00) begin
      fails++;
      $display("FAIL reset state led=%b press=%b",
               led, key_press);
    end
    rst_n = 1'b1; step(20);
    key = 2'b10; step(20);
    key = 2'b11; step(20);
    key = 2'b01; step(3);
    key = 2'b11; step(20);
    repeat (3) begin
      key = 2'b10; step(10);
      key = 2'b11; step(25);
    end
    repeat (2) begin
      key = 2'b01; step(10);
      key = 2'b11; step(15);
    end
    key = 2'b00; step(10);
    key = 2'b11; step(20);
    key = 2'b10; step(4);
    rst_n = 1'b0; key = 2'b11; step(3);
    rst_n = 1'b1; step(20);
    repeat (200) begin
      rst_n = ($urandom_range(0, 24) != 0);
      key = 2'($urandom);
      step($urandom_range(1, 12));
    end
    rst_n = 1'b1; key = 2'b11; step(30);
    done = 1;
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
